// File: rtl/mux_share_arbiter_if.sv
// Bus bundle between the switch-driven sources and the shared mux arbiter.
// master: the side that issues requests and supplies data.
// slave:  the arbiter that grants and drives the muxed output.
interface mux_share_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [1:0]       grant;
    logic             valid;
    logic [WIDTH-1:0] data_out;

    modport master (
        output req, data_a, data_b,
        input  grant, valid, data_out
    );

    modport slave (
        input  req, data_a, data_b,
        output grant, valid, data_out
    );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter time-sharing one WIDTH-bit 2:1 mux between A and B.
// A tenure counter limits how long one side holds the mux while the other
// side waits; a lone requester keeps the mux indefinitely.
module mux_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    mux_share_arbiter_if.slave    bus
);
    localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;   // 0 = A served last, 1 = B served last
    logic          at_limit;

    assign at_limit = (cnt_q == CNT_LIMIT);

    // State, tenure counter and round-robin pointer registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state decision: handover on drop, timeout only against a competitor
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                case (bus.req)
                    2'b01:   state_d = GNT_A;
                    2'b10:   state_d = GNT_B;
                    2'b11:   state_d = last_q ? GNT_A : GNT_B;
                    default: state_d = IDLE;
                endcase
            end
            GNT_A: begin
                if (!bus.req[0]) begin
                    state_d = bus.req[1] ? GNT_B : IDLE;
                end else if (bus.req[1] && at_limit) begin
                    state_d = GNT_B;
                end else begin
                    cnt_d = at_limit ? '0 : cnt_q + CW'(1);
                end
            end
            GNT_B: begin
                if (!bus.req[1]) begin
                    state_d = bus.req[0] ? GNT_A : IDLE;
                end else if (bus.req[0] && at_limit) begin
                    state_d = GNT_A;
                end else begin
                    cnt_d = at_limit ? '0 : cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Any state change starts a fresh tenure and records who now holds it
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == GNT_A) begin
                last_d = 1'b0;
            end else if (state_d == GNT_B) begin
                last_d = 1'b1;
            end
        end
    end

    assign bus.grant = (state_q == GNT_A) ? 2'b01 :
                       (state_q == GNT_B) ? 2'b10 : 2'b00;
    assign bus.valid = (state_q == GNT_A) || (state_q == GNT_B);

    // Unregistered data path: the live source selected by the registered state
    always_comb begin
        bus.data_out = '0;
        case (state_q)
            GNT_A:   bus.data_out = bus.data_a;
            GNT_B:   bus.data_out = bus.data_b;
            default: bus.data_out = '0;
        endcase
    end
endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter: the driver updates a tenure-based
// reference model and queues the expected grant/data; the monitor checks them.
module tb_mux_share_arbiter;
    localparam int WIDTH = 4;
    localparam int HOLD  = 4;
    localparam logic [WIDTH-1:0] DA = 4'h3;
    localparam logic [WIDTH-1:0] DB = 4'hC;

    typedef struct {
        logic [1:0]       g;
        logic [WIDTH-1:0] d;
        string            tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    string phase = "init";

    // Reference model: who holds the mux, cycles in the current hold window,
    // and who was served last (1 = A, 2 = B, 0 = nobody)
    int holder_m = 0;
    int tenure_m = 0;
    int last_m   = 2;

    mux_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_share_arbiter #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic model_reset();
        holder_m = 0;
        tenure_m = 0;
        last_m   = 2;
    endtask

    // One rising edge of the arbitration rules, applied to the sampled req
    task automatic model_step(input logic [1:0] r);
        int nh;
        bit mine;
        bit other;
        nh = holder_m;
        if (holder_m == 0) begin
            if (r == 2'b01)      nh = 1;
            else if (r == 2'b10) nh = 2;
            else if (r == 2'b11) nh = (last_m == 2) ? 1 : 2;
        end else begin
            mine  = r[holder_m - 1];
            other = r[2 - holder_m];
            if (mine && !(other && tenure_m == HOLD)) nh = holder_m;
            else if (other)                           nh = 3 - holder_m;
            else                                      nh = 0;
        end
        if (nh != holder_m) begin
            tenure_m = (nh == 0) ? 0 : 1;
            if (nh != 0) last_m = nh;
        end else if (nh != 0) begin
            tenure_m = (tenure_m % HOLD) + 1;
        end
        holder_m = nh;
    endtask

    // Drive inputs for the coming edge and queue what the DUT must show after it
    task automatic apply(input logic [1:0] r, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        exp_t e;
        bus.req    = r;
        bus.data_a = da;
        bus.data_b = db;
        model_step(r);
        e.g   = (holder_m == 1) ? 2'b01 : (holder_m == 2) ? 2'b10 : 2'b00;
        e.d   = (holder_m == 1) ? da : (holder_m == 2) ? db : '0;
        e.tag = phase;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            apply(r, DA, DB);
        end
    endtask

    // Monitor: every edge with a pending expectation is one transaction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, "_grant"}, 32'(bus.grant), 32'(e.g));
                check({e.tag, "_valid"}, 32'(bus.valid), 32'(e.g != 2'b00));
                check({e.tag, "_data"},  32'(bus.data_out), 32'(e.d));
                $display("[TB] %s t=%0t grant=%b data_out=%h", e.tag, $time, bus.grant, bus.data_out);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] r;
        bus.req    = 2'b00;
        bus.data_a = DA;
        bus.data_b = DB;

        // Reset state while held in reset
        @(posedge clk);
        @(negedge clk);
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_data",  32'(bus.data_out), 32'd0);

        // Continuous contention from reset: A x4, B x4, A x4, B x2
        phase = "contention";
        rst = 1'b0;
        model_reset();
        apply(2'b11, DA, DB);
        drive(2'b11, 13);

        // Reset mid-tenure in GNT_B drops the grant before the next edge
        phase = "reset_mid";
        @(negedge clk);
        bus.req = 2'b11;
        #2 rst = 1'b1;
        #1;
        check("async_reset_grant", 32'(bus.grant), 32'd0);
        check("async_reset_valid", 32'(bus.valid), 32'd0);
        check("async_reset_data",  32'(bus.data_out), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        phase = "after_reset";
        apply(2'b11, DA, DB);

        // Lone requester A keeps the mux through counter wrap, then releases
        phase = "solo_a";
        drive(2'b01, 10);
        drive(2'b00, 2);

        // Early release by A hands over directly, then round robin returns to A
        phase = "early_release";
        drive(2'b01, 1);
        drive(2'b11, 1);
        drive(2'b10, 3);
        drive(2'b11, 6);

        // Tie from IDLE after B was served last goes to A
        phase = "idle_tie";
        drive(2'b00, 2);
        drive(2'b10, 2);
        drive(2'b00, 2);
        drive(2'b11, 1);

        // Live data path while B holds the mux
        phase = "live_data";
        drive(2'b10, 2);
        @(posedge clk);
        #3;
        bus.data_b = 4'h5;
        #1;
        check("live_data_b", 32'(bus.data_out), 32'h5);
        bus.data_a = 4'hA;
        #1;
        check("live_data_a_ignored", 32'(bus.data_out), 32'h5);

        // Randomized traffic with random data
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) r = 2'b11;
            @(negedge clk);
            apply(r, 4'($urandom), 4'($urandom));
        end

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
